// File: rtl/cop_pkg.sv
// cop_pkg: shared opcode constants, field ranges and FSM state encoding for the COP1 sequencer
package cop_pkg;
    localparam logic [5:0] COP1_OPCODE = 6'b010001;
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RD_HI  = 20;
    localparam int RD_LO  = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WB,
        ABORT
    } cop_state_t;
endpackage

// File: rtl/cop_wait_counter.sv
// cop_wait_counter: saturating wait-cycle counter with clear/enable; threshold compare when COP1_TIMEOUT_EN is defined
module cop_wait_counter #(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
`ifdef COP1_TIMEOUT_EN
    ,
    output logic             at_thresh
`endif
);

    // Clear wins over enable; counting stops at all-ones instead of wrapping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) count <= '0;
        else if (clr) count <= '0;
        else if (en && count != '1) count <= count + 1'b1;
    end

`ifdef COP1_TIMEOUT_EN
    assign at_thresh = (count == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: rtl/cop1_issue_ctrl.sv
// cop1_issue_ctrl: issues COP1 instructions to the coprocessor, stalls decode until done, strobes write-back; watchdog under COP1_TIMEOUT_EN
module cop1_issue_ctrl
    import cop_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      inst_in,
    input  logic             inst_valid,
    output logic             stall,
    output logic             cop_valid,
    output logic [31:0]      cop_inst,
    input  logic             cop_ready,
    input  logic             opr_finished,
    input  logic [31:0]      cop_result,
    output logic             wb_en,
    output logic [31:0]      wb_data,
    output logic [4:0]       wb_rd,
    output logic [CNT_W-1:0] wait_cycles,
    output logic             timeout_err
);

    cop_state_t       state;
    logic             stall_r;
    logic             hit;
    logic [CNT_W-1:0] count;
`ifdef COP1_TIMEOUT_EN
    logic             at_thresh;
`endif

    assign hit   = inst_valid && (inst_in[OPC_HI:OPC_LO] == COP1_OPCODE);
    assign stall = stall_r | (state == IDLE && hit);
    assign wb_rd = cop_inst[RD_HI:RD_LO];

    cop_wait_counter #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .clr       (state == ISSUE && cop_ready),
        .en        (state == WAIT),
        .count     (count)
`ifdef COP1_TIMEOUT_EN
        ,
        .at_thresh (at_thresh)
`endif
    );

    // Sequencer: latch, hand off, wait for completion (finish beats the watchdog), strobe write-back
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            stall_r     <= 1'b0;
            cop_valid   <= 1'b0;
            cop_inst    <= '0;
            wb_en       <= 1'b0;
            wb_data     <= '0;
            wait_cycles <= '0;
`ifdef COP1_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
        end else begin
            wb_en <= 1'b0;
            case (state)
                IDLE: if (hit) begin
                    cop_inst  <= inst_in;
                    cop_valid <= 1'b1;
                    stall_r   <= 1'b1;
                    state     <= ISSUE;
                end
                ISSUE: if (cop_ready) begin
                    cop_valid <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: if (opr_finished) begin
                    wb_data     <= cop_result;
                    wait_cycles <= count;
                    wb_en       <= 1'b1;
                    stall_r     <= 1'b0;
                    state       <= WB;
                end
`ifdef COP1_TIMEOUT_EN
                else if (at_thresh) begin
                    timeout_err <= 1'b1;
                    stall_r     <= 1'b0;
                    state       <= ABORT;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

`ifndef COP1_TIMEOUT_EN
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_cop1_issue_ctrl.sv
// tb_cop1_issue_ctrl: directed and randomized checks of cop1_issue_ctrl against a transaction-level expectation model
module tb_cop1_issue_ctrl;

    localparam int TO = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [31:0]   inst_in = '0;
    logic          inst_valid = 1'b0;
    logic          stall;
    logic          cop_valid;
    logic [31:0]   cop_inst;
    logic          cop_ready = 1'b0;
    logic          opr_finished = 1'b0;
    logic [31:0]   cop_result = '0;
    logic          wb_en;
    logic [31:0]   wb_data;
    logic [4:0]    wb_rd;
    logic [CW-1:0] wait_cycles;
    logic          timeout_err;

    int n_chk  = 0;
    int n_fail = 0;
    bit exp_terr = 1'b0;

    cop1_issue_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_in      (inst_in),
        .inst_valid   (inst_valid),
        .stall        (stall),
        .cop_valid    (cop_valid),
        .cop_inst     (cop_inst),
        .cop_ready    (cop_ready),
        .opr_finished (opr_finished),
        .cop_result   (cop_result),
        .wb_en        (wb_en),
        .wb_data      (wb_data),
        .wb_rd        (wb_rd),
        .wait_cycles  (wait_cycles),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_cop1();
        logic [31:0] r;
        r = $urandom;
        return {6'b010001, r[25:0]};
    endfunction

    // One complete COP1 transaction: expected outputs follow from the instruction, the
    // handshake delay and the number of WAIT cycles before the finish pulse.
    task automatic do_op(input logic [31:0] inst, input int rdy_dly, input int n,
                         input logic [31:0] res, input bit b2b, input logic [31:0] nxt);
        inst_in = inst; inst_valid = 1'b1; #1;
        check("stall_present", 32'(stall), 1);
        tick();
        inst_valid = 1'b0; inst_in = $urandom;
        check("cop_valid_issue", 32'(cop_valid), 1);
        check("cop_inst_issue", cop_inst, inst);
        check("stall_issue", 32'(stall), 1);
        for (int i = 0; i < rdy_dly; i++) begin
            cop_ready = 1'b0; opr_finished = 1'($urandom_range(0, 1)); cop_result = $urandom;
            tick();
            check("cop_valid_hold", 32'(cop_valid), 1);
            check("cop_inst_hold", cop_inst, inst);
            check("wb_en_issue", 32'(wb_en), 0);
        end
        cop_ready = 1'b1; opr_finished = 1'($urandom_range(0, 1));
        tick();
        cop_ready = 1'b0; opr_finished = 1'b0;
        check("cop_valid_accepted", 32'(cop_valid), 0);
        check("stall_wait", 32'(stall), 1);
        for (int i = 0; i < n; i++) begin
            cop_result = $urandom;
            tick();
            check("stall_wait_loop", 32'(stall), 1);
            check("wb_en_wait_loop", 32'(wb_en), 0);
        end
        opr_finished = 1'b1; cop_result = res;
        tick();
        opr_finished = 1'b0; cop_result = $urandom;
        check("wb_en", 32'(wb_en), 1);
        check("wb_data", wb_data, res);
        check("wb_rd", 32'(wb_rd), (inst >> 16) & 32'd31);
        check("wait_cycles", 32'(wait_cycles), 32'(n));
        check("stall_wb", 32'(stall), 0);
        check("timeout_err_wb", 32'(timeout_err), 32'(exp_terr));
        if (b2b) begin
            inst_in = nxt; inst_valid = 1'b1; #1;
            check("stall_wb_presented", 32'(stall), 0);
        end else inst_valid = 1'b0;
        tick();
        check("wb_en_one_cycle", 32'(wb_en), 0);
        check("cop_valid_idle", 32'(cop_valid), 0);
        if (b2b) check("stall_idle_represent", 32'(stall), 1);
    endtask

    initial begin
        logic [31:0] nxt;
        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", 32'(stall), 0);
        check("rst_cop_valid", 32'(cop_valid), 0);
        check("rst_wb_en", 32'(wb_en), 0);
        check("rst_cop_inst", cop_inst, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_wb_rd", 32'(wb_rd), 0);
        check("rst_wait_cycles", 32'(wait_cycles), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // non-COP1 stream, opcode 0 then other random non-COP1 opcodes
        for (int i = 0; i < 20; i++) begin
            logic [31:0] r;
            logic [5:0]  op;
            r  = $urandom;
            op = (i < 10) ? 6'b000000 : 6'($urandom_range(0, 63));
            if (op == 6'b010001) op = 6'b010010;
            inst_in = {op, r[25:0]}; inst_valid = 1'b1;
            opr_finished = 1'($urandom_range(0, 1)); cop_ready = 1'($urandom_range(0, 1));
            #1;
            check("noncop_stall", 32'(stall), 0);
            tick();
            check("noncop_cop_valid", 32'(cop_valid), 0);
            check("noncop_wb_en", 32'(wb_en), 0);
        end
        inst_valid = 1'b0; opr_finished = 1'b0; cop_ready = 1'b0;
        tick();

        // directed: 0x46041000, immediate accept, finish 5 cycles after acceptance
        do_op(32'h4604_1000, 0, 5, 32'hDEAD_BEEF, 1'b0, '0);
        // cop_ready held low for 3 cycles
        do_op(rand_cop1(), 3, 2, $urandom, 1'b0, '0);
        // minimum occupancy, then back-to-back with a COP1 presented during WB
        nxt = rand_cop1();
        do_op(rand_cop1(), 0, 0, $urandom, 1'b1, nxt);
        do_op(nxt, 1, 3, $urandom, 1'b0, '0);

        // randomized transactions
        for (int k = 0; k < 12; k++) begin
`ifdef COP1_TIMEOUT_EN
            do_op(rand_cop1(), $urandom_range(0, 3), $urandom_range(0, TO - 1), $urandom, 1'b0, '0);
`else
            do_op(rand_cop1(), $urandom_range(0, 3), $urandom_range(0, 20), $urandom, 1'b0, '0);
`endif
        end

`ifdef COP1_TIMEOUT_EN
        // finish coincident with the threshold: finish wins
        do_op(rand_cop1(), 0, TO - 1, 32'h1234_5678, 1'b0, '0);
        // watchdog: no finish, pulse during ISSUE must be ignored
        inst_in = rand_cop1(); inst_valid = 1'b1;
        tick();
        inst_valid = 1'b0; opr_finished = 1'b1;
        tick();
        opr_finished = 1'b0; cop_ready = 1'b1;
        tick();
        cop_ready = 1'b0;
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            check("to_stall_wait", 32'(stall), 1);
            check("to_err_wait", 32'(timeout_err), 0);
        end
        tick();
        check("abort_stall", 32'(stall), 0);
        check("abort_timeout_err", 32'(timeout_err), 1);
        check("abort_wb_en", 32'(wb_en), 0);
        tick();
        check("post_abort_wb_en", 32'(wb_en), 0);
        check("post_abort_err_sticky", 32'(timeout_err), 1);
        exp_terr = 1'b1;
        do_op(rand_cop1(), 1, 2, $urandom, 1'b0, '0);
`else
        // no watchdog: long waits never abort
        do_op(rand_cop1(), 0, 3 * TO, $urandom, 1'b0, '0);
`endif

        // reset in WAIT, then a late finish pulse must be dropped
        inst_in = rand_cop1(); inst_valid = 1'b1;
        tick();
        inst_valid = 1'b0; cop_ready = 1'b1;
        tick();
        cop_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0; #1;
        check("midrst_stall", 32'(stall), 0);
        check("midrst_cop_valid", 32'(cop_valid), 0);
        check("midrst_wb_en", 32'(wb_en), 0);
        check("midrst_cop_inst", cop_inst, 0);
        check("midrst_wb_data", wb_data, 0);
        check("midrst_wb_rd", 32'(wb_rd), 0);
        check("midrst_wait_cycles", 32'(wait_cycles), 0);
        check("midrst_timeout_err", 32'(timeout_err), 0);
        exp_terr = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();
        opr_finished = 1'b1;
        tick();
        opr_finished = 1'b0;
        check("late_finish_wb_en", 32'(wb_en), 0);
        check("late_finish_stall", 32'(stall), 0);
        tick();
        check("late_finish_wb_en2", 32'(wb_en), 0);
        do_op(rand_cop1(), 2, 4, $urandom, 1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cop1_issue_ctrl.md
# cop1_issue_ctrl

Sequencer for the processor's multi-cycle coprocessor-1 path. It sits between decode and the external coprocessor. It detects COP1 instructions (opcode 6'b010001), issues each one over a valid/ready handshake, and stalls fetch/decode until the coprocessor signals completion. It then returns the result on a one-cycle write-back strobe. An optional watchdog aborts operations that never finish.

## Interface
Parameters:
- TIMEOUT_CYCLES, 256: maximum WAIT cycles before abort; must be ≥2 and ≤ 2^CNT_W − 1.
- CNT_W, 16: width of the wait-cycle counter.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- inst_in  in  32  instruction from decode.
- inst_valid  in  1  inst_in is valid this cycle.
- stall  out  1  hold fetch/decode.
- cop_valid  out  1  issue request to the coprocessor.
- cop_inst  out  32  latched COP1 instruction.
- cop_ready  in  1  coprocessor accepts the request.
- opr_finished  in  1  coprocessor result is valid (single-cycle pulse).
- cop_result  in  32  coprocessor result data.
- wb_en  out  1  write-back strobe.
- wb_data  out  32  captured result.
- wb_rd  out  5  destination register, taken as cop_inst[20:16].
- wait_cycles  out  CNT_W  cycle count of the last completed operation.
- timeout_err  out  1  sticky watchdog flag.

## Operation
- The FSM has five states: IDLE, ISSUE, WAIT, WB, ABORT.
- **IDLE**
  - If inst_valid && inst_in[31:26]==COP1: latch inst_in into cop_inst, go to ISSUE.
  - Other opcodes are ignored; stall stays 0.
- **ISSUE**
  - cop_valid=1, cop_inst held stable.
  - On cop_valid && cop_ready: clear the counter, go to WAIT.
  - cop_valid is never dropped before acceptance.
- **WAIT**
  - The counter increments every cycle (saturating).
  - On opr_finished: capture cop_result into wb_data, load the counter value into wait_cycles, go to WB.
  - opr_finished is ignored in any state other than WAIT.
- **WB**
  - wb_en=1 for exactly one cycle, then go to IDLE.
- **ABORT** (only when the timeout is compiled in)
  - Entered from WAIT when counter==TIMEOUT_CYCLES−1 and opr_finished==0.
  - Sets timeout_err, which stays set until reset.
  - No write-back occurs; go to IDLE next cycle.
- If opr_finished arrives in the same cycle the timeout threshold is reached, finish wins: go to WB, no error.
- **stall**
  - Combinational 1 in IDLE when a COP1 instruction is presented.
  - 1 throughout ISSUE and WAIT.
  - 0 in WB, ABORT and all other IDLE cycles.
- The counter is CNT_W bits unsigned and saturates at all-ones; it never wraps.
- **Reset** (at any time, including mid-operation)
  - State returns to IDLE.
  - stall, cop_valid, wb_en, timeout_err = 0.
  - cop_inst, wb_data, wait_cycles, wb_rd = 0.
  - Any in-flight operation is dropped silently.

## Timing
- Cycle 0: COP1 presented in IDLE, stall=1.
- Cycle 1: ISSUE, cop_valid=1.
- With cop_ready=1 in cycle 1, WAIT starts in cycle 2.
- opr_finished in cycle 2+N gives wb_en in cycle 3+N and wait_cycles=N.
- Minimum COP1 occupancy is 4 cycles (N=0).
- A COP1 presented in the WB cycle is not accepted; decode re-presents it in the next IDLE cycle.
- Back-to-back COP1 instructions therefore have a 1-cycle IDLE gap.
- All outputs are registered except stall in IDLE.

## Configuration
- **COP1_TIMEOUT_EN defined:** watchdog and ABORT state present; timeout_err is functional.
- **Not defined:**
  - ABORT state and the comparator are removed.
  - WAIT waits indefinitely for opr_finished.
  - timeout_err is tied to 0.
  - TIMEOUT_CYCLES is unused.

## Structure
- Shared package cop_pkg holds:
  - the COP1_OPCODE = 6'b010001 constant;
  - the state enum (IDLE, ISSUE, WAIT, WB, ABORT);
  - the opcode field range constants.
- Sub-module cop_wait_counter: saturating CNT_W counter with clear and enable, plus the threshold compare output under COP1_TIMEOUT_EN.

## Test plan
- Non-COP1 stream (opcode 6'b000000, inst_valid=1 for 20 cycles) -> stall=0, cop_valid=0, wb_en=0 throughout.
- COP1 0x4604_1000, cop_ready=1 immediately, opr_finished 5 cycles after acceptance with cop_result=0xDEADBEEF:
  - wb_en=1 for one cycle with wb_data=0xDEADBEEF, wb_rd=4, wait_cycles=5;
  - stall high from presentation until WB.
- cop_ready held low for 3 cycles -> cop_valid and cop_inst stable for 4 cycles; WAIT begins only after acceptance.
- COP1_TIMEOUT_EN, TIMEOUT_CYCLES=8, no opr_finished:
  - ABORT after 8 WAIT cycles, timeout_err=1 sticky, stall released, no wb_en;
  - an opr_finished pulse during ISSUE is ignored.
- Reset asserted (low) in WAIT:
  - all outputs 0, state IDLE;
  - a late opr_finished after reset release produces no wb_en.
- opr_finished coincident with the timeout threshold (TIMEOUT_CYCLES=8) -> wb_en=1, timeout_err stays 0.
